picorv32_wait_mem: RTL

//   Single-port word memory slave for the picorv32 native memory interface (mem_valid/mem_ready).

---
 rtl/picorv32_wait_mem.sv | 130 +++++++++++++
 1 files changed

// File: rtl/picorv32_wait_mem.sv
// Word-addressed memory slave for the picorv32 native bus with a base-address window,
// per-access-type wait states and out-of-window error reporting.
module picorv32_wait_mem #(
  parameter int unsigned WORDS     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned D_LATENCY = 0,
  parameter int unsigned I_LATENCY = 0,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WIN_BYTES = WORDS * 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               inw_q;

  logic [31:0]        offset_c;
  logic               in_window_c;
  logic               accept_c;
  logic               access_c;

  logic [31:0]        mem [WORDS];

  // Window decode: unsigned offset, addresses below the base never wrap into the window
  always_comb begin
    offset_c    = mem_addr - BASE_ADDR;
    in_window_c = (mem_addr >= BASE_ADDR) && (offset_c < 32'(WIN_BYTES));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    access_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          accept_c = 1'b1;
          cnt_d    = mem_instr ? CNT_W'(I_LATENCY) : CNT_W'(D_LATENCY);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A dropped request is abandoned without side effects
        if (!mem_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          access_c = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request capture at acceptance; the bus is free to change afterwards in RESP
  always_ff @(posedge clk) begin
    if (accept_c) begin
      idx_q   <= offset_c[IDX_W+1:2];
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      inw_q   <= in_window_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= access_c;
      mem_err   <= access_c & ~inw_q;
      if (access_c) begin
        mem_rdata <= inw_q ? mem[idx_q] : ERR_DATA;
      end
    end
  end

  // Byte-lane write; read above samples the pre-write word on the same edge
  always_ff @(posedge clk) begin
    if (resetn && access_c && inw_q) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_q[k]) begin
          mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

endmodule
